// File: rtl/datapath_mk3.sv
// Shared-bus datapath: register file, immediate source, two-operand ALU with latched
// Z/N/C/V flags, and an iterative shift-add multiplier with a busy/done handshake.
module datapath_mk3 #(
    parameter  int WIDTH    = 32,
    parameter  int NREGS    = 32,
    parameter  int ZERO_REG = 1,
    localparam int IW       = $clog2(NREGS),
    localparam int SW       = $clog2(WIDTH),
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       alu_function_sel,
    input  logic             alu_store_1,
    input  logic             alu_store_2,
    input  logic             alu_broadcast,
    input  logic             alu_start,
    input  logic [IW-1:0]    reg_rd_index,
    input  logic [IW-1:0]    reg_wr_index,
    input  logic             register_read_enable,
    input  logic             register_write_enable,
    input  logic [WIDTH-1:0] imm,
    input  logic             imm_EN,
    output logic [WIDTH-1:0] bus,
    output logic [3:0]       flags,
    output logic             bus_conflict,
    output logic             mul_busy,
    output logic             mul_done
);

    // state  | meaning
    // S_IDLE | multiplier waiting for alu_start with sel=11
    // S_BUSY | one shift-add step per edge, cnt_q steps remaining
    typedef enum logic {S_IDLE, S_BUSY} mul_state_e;

    localparam logic [3:0] OP_MUL = 4'd11;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH:0]   sum, diff;
    logic [SW-1:0]    shamt;
    logic             c_flag, v_flag;

    mul_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mul_res_q, mul_res_d;
    logic             done_q, done_d;
    logic             wr_allowed;

    assign rd_data = ((ZERO_REG != 0) && (reg_rd_index == '0)) ? '0 : regs_q[reg_rd_index];

    always_comb begin
        bus = '0;
        if (imm_EN)                    bus = imm;
        else if (alu_broadcast)        bus = alu_out;
        else if (register_read_enable) bus = rd_data;
    end

    assign bus_conflict = (imm_EN & alu_broadcast) | (imm_EN & register_read_enable)
                        | (alu_broadcast & register_read_enable);

    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign shamt = b_q[SW-1:0];

    always_comb begin
        alu_out = '0;
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        case (alu_function_sel)
            4'd1: begin
                alu_out = sum[WIDTH-1:0];
                c_flag  = sum[WIDTH];
                v_flag  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd2: begin
                alu_out = diff[WIDTH-1:0];
                // diff[WIDTH] is the borrow; carry means no borrow
                c_flag  = ~diff[WIDTH];
                v_flag  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd3:    alu_out = a_q & b_q;
            4'd4:    alu_out = a_q | b_q;
            4'd5:    alu_out = a_q ^ b_q;
            4'd6:    alu_out = a_q << shamt;
            4'd7:    alu_out = a_q >> shamt;
            4'd8:    alu_out = $unsigned($signed(a_q) >>> shamt);
            4'd9:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'd10:   alu_out = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            4'd11:   alu_out = mul_res_q;
            default: alu_out = '0;
        endcase
    end

    assign flags_d = {(alu_out == '0), alu_out[WIDTH-1], c_flag, v_flag};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
        end else begin
            if (alu_store_1)   a_q     <= bus;
            if (alu_store_2)   b_q     <= bus;
            if (alu_broadcast) flags_q <= flags_d;
        end
    end

    assign wr_allowed = register_write_enable && !((ZERO_REG != 0) && (reg_wr_index == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_allowed) begin
            regs_q[reg_wr_index] <= bus;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        mul_res_d = mul_res_q;
        done_d    = 1'b0;
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            S_IDLE: begin
                if (alu_start && (alu_function_sel == OP_MUL)) begin
                    state_d  = S_BUSY;
                    mcand_d  = a_q;
                    mplier_d = b_q;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                end
            end
            S_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = S_IDLE;
                    mul_res_d = acc_step;
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mul_res_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            mul_res_q <= mul_res_d;
            done_q    <= done_d;
        end
    end

    assign flags    = flags_q;
    assign mul_busy = (state_q == S_BUSY);
    assign mul_done = done_q;

endmodule

// File: tb/tb_datapath_mk3.sv
// Directed bench for datapath_mk3: expected values are queued as stimulus is driven and
// popped when the corresponding output is sampled.
module tb_datapath_mk3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  alu_function_sel;
    logic        alu_store_1, alu_store_2, alu_broadcast, alu_start;
    logic [4:0]  reg_rd_index, reg_wr_index;
    logic        register_read_enable, register_write_enable;
    logic [31:0] imm;
    logic        imm_EN;
    logic [31:0] bus;
    logic [3:0]  flags;
    logic        bus_conflict, mul_busy, mul_done;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q [$];

    logic [3:0]  op_sel [12];
    logic [31:0] op_exp [12];
    int busy_n, done_n, done_at;
    bit found;

    datapath_mk3 #(.WIDTH(32), .NREGS(32), .ZERO_REG(1)) dut (
        .clk(clk), .reset_n(reset_n), .alu_function_sel(alu_function_sel),
        .alu_store_1(alu_store_1), .alu_store_2(alu_store_2),
        .alu_broadcast(alu_broadcast), .alu_start(alu_start),
        .reg_rd_index(reg_rd_index), .reg_wr_index(reg_wr_index),
        .register_read_enable(register_read_enable),
        .register_write_enable(register_write_enable),
        .imm(imm), .imm_EN(imm_EN), .bus(bus), .flags(flags),
        .bus_conflict(bus_conflict), .mul_busy(mul_busy), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%0h", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imm_EN = 0; alu_store_1 = 0; alu_store_2 = 0; alu_broadcast = 0;
        alu_start = 0; register_read_enable = 0; register_write_enable = 0;
    endtask

    task automatic load_reg(input logic [4:0] idx, input logic [31:0] v);
        imm = v; imm_EN = 1; register_write_enable = 1; reg_wr_index = idx;
        tick(); idle();
    endtask

    task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
        imm = a; imm_EN = 1; alu_store_1 = 1;
        tick(); idle();
        imm = b; imm_EN = 1; alu_store_2 = 1;
        tick(); idle();
    endtask

    initial begin
        op_sel = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd13, 4'd15, 4'd8};
        op_exp = '{32'h0, 32'h24, 32'hF0F01234, 32'hF0F01210, 32'h0F012340, 32'h0F0F0123,
                   32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF0F0123};
        reset_n = 0; alu_function_sel = 0; imm = 0; reg_rd_index = 0; reg_wr_index = 0;
        idle();
        #1;
        expect_v(0); chk("rst_bus", bus);
        expect_v(0); chk("rst_flags", flags);
        expect_v(0); chk("rst_busy", mul_busy);
        expect_v(0); chk("rst_done", mul_done);
        expect_v(0); chk("rst_conflict", bus_conflict);
        @(negedge clk); reset_n = 1;
        tick();

        // reset in the middle of activity
        load_reg(3, 32'd5);
        load_ab(32'd5, 32'd5);
        register_read_enable = 1; reg_rd_index = 3; #1;
        expect_v(5); chk("pre_rst_reg3", bus);
        idle();
        alu_function_sel = 2; alu_broadcast = 1; #1;
        expect_v(0); chk("pre_rst_sub", bus);
        tick(); idle();
        expect_v(4'b1010); chk("pre_rst_flags", flags);
        alu_function_sel = 11; alu_start = 1;
        tick(); idle();
        expect_v(1); chk("pre_rst_busy", mul_busy);
        tick(); tick();
        #1 reset_n = 0; #1;
        expect_v(0); chk("async_rst_busy", mul_busy);
        @(negedge clk); reset_n = 1;
        tick();
        register_read_enable = 1; reg_rd_index = 3; #1;
        expect_v(0); chk("post_rst_reg3", bus);
        idle();
        expect_v(0); chk("post_rst_flags", flags);
        alu_function_sel = 1; alu_broadcast = 1; #1;
        expect_v(0); chk("post_rst_a_plus_b", bus);
        idle();
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (mul_done) done_n++;
            tick();
        end
        expect_v(0); chk("aborted_mul_no_done", done_n);

        // bus priority and conflict
        load_reg(2, 32'd7);
        imm = 9; imm_EN = 1; register_read_enable = 1; reg_rd_index = 2; #1;
        expect_v(9); chk("prio_imm_bus", bus);
        expect_v(1); chk("prio_imm_conflict", bus_conflict);
        idle();
        tick();
        register_read_enable = 1; reg_rd_index = 2; #1;
        expect_v(7); chk("prio_reg_bus", bus);
        expect_v(0); chk("prio_reg_conflict", bus_conflict);
        idle(); #1;
        expect_v(0); chk("no_source_bus", bus);
        load_ab(32'h10, 32'h20);
        alu_function_sel = 4; alu_broadcast = 1; register_read_enable = 1; #1;
        expect_v(32'h30); chk("prio_alu_bus", bus);
        expect_v(1); chk("prio_alu_conflict", bus_conflict);
        idle();

        // ADD / SUB flags
        load_ab(32'hFFFFFFFF, 32'h1);
        alu_function_sel = 1; alu_broadcast = 1; #1;
        expect_v(0); chk("add_bus", bus);
        tick(); idle();
        expect_v(4'b1010); chk("add_flags", flags);
        load_ab(32'h7FFFFFFF, 32'hFFFFFFFF);
        alu_function_sel = 2; alu_broadcast = 1; #1;
        expect_v(32'h80000000); chk("sub_bus", bus);
        tick(); idle();
        expect_v(4'b0101); chk("sub_flags", flags);

        // remaining ALU ops, sel 8 last so its flags remain latched
        load_ab(32'hF0F01234, 32'h24);
        for (int i = 0; i < 12; i++) begin
            alu_function_sel = op_sel[i]; alu_broadcast = 1; #1;
            expect_v(op_exp[i]); chk($sformatf("alu_sel%0d", op_sel[i]), bus);
            tick(); idle();
        end
        expect_v(4'b0100); chk("sra_flags", flags);

        // store and broadcast in the same cycle
        alu_function_sel = 1; alu_broadcast = 1; alu_store_1 = 1;
        tick(); idle();
        alu_function_sel = 4; alu_broadcast = 1; #1;
        expect_v(32'hF0F0127C); chk("store_bcast_a", bus);
        idle();
        tick();

        // zero register and read-during-write
        load_reg(0, 32'hAB);
        register_read_enable = 1; reg_rd_index = 0; #1;
        expect_v(0); chk("zero_reg", bus);
        idle();
        load_reg(4, 32'h22);
        imm = 32'h11; imm_EN = 1; register_write_enable = 1; reg_wr_index = 4;
        #1 imm_EN = 0; register_read_enable = 1; reg_rd_index = 4; #1;
        expect_v(32'h22); chk("rdw_old", bus);
        imm_EN = 1; register_read_enable = 0;
        tick(); idle();
        register_read_enable = 1; reg_rd_index = 4; #1;
        expect_v(32'h11); chk("rdw_new", bus);
        idle();
        tick();

        // multiply with operand rewrite and an ignored start while busy
        load_ab(32'h00012345, 32'h00000100);
        alu_function_sel = 11; alu_start = 1;
        tick(); idle();
        busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (mul_busy) busy_n++;
            if (mul_done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (c == 5) begin imm = 32'hDEAD; imm_EN = 1; alu_store_1 = 1; end
            if (c == 8) alu_start = 1;
            tick(); idle();
        end
        expect_v(32); chk("mul_busy_cycles", busy_n);
        expect_v(1);  chk("mul_done_pulses", done_n);
        expect_v(32); chk("mul_done_time", done_at);
        alu_broadcast = 1; #1;
        expect_v(32'h01234500); chk("mul_result", bus);
        idle();
        tick();

        alu_function_sel = 1; alu_start = 1;
        tick(); idle();
        expect_v(0); chk("start_wrong_sel", mul_busy);

        // back-to-back multiply restarted in the done cycle
        load_ab(32'hFFFFFFFF, 32'hFFFFFFFF);
        alu_function_sel = 11; alu_start = 1;
        tick(); idle();
        alu_broadcast = 1; #1;
        expect_v(32'h01234500); chk("bcast_during_busy", bus);
        idle();
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (mul_done) found = 1;
            else tick();
        end
        expect_v(1); chk("first_done_seen", found);
        alu_broadcast = 1; #1;
        expect_v(32'h1); chk("mul_all_ones", bus);
        idle();
        alu_start = 1;
        tick(); idle();
        expect_v(1); chk("restart_busy", mul_busy);
        expect_v(0); chk("restart_done_low", mul_done);
        busy_n = 0; found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (mul_busy) busy_n++;
            if (mul_done) found = 1;
            else tick();
        end
        expect_v(32); chk("restart_busy_cycles", busy_n);
        alu_broadcast = 1; #1;
        expect_v(32'h1); chk("restart_result", bus);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/datapath_mk3.md
# datapath_mk3

Parametrised successor to the MkII datapath: a single shared bus connecting an NREGS×WIDTH register file, an immediate source and a two-operand ALU. It adds a defined bus-source priority and conflict flag, separate read and write register indices, a wider ALU op set, latched Z/N/C/V flags, and an iterative shift-add multiplier with a busy/done handshake. It sits under the control unit, which drives every enable each cycle.

## Interface
- WIDTH, 32, datapath and register width (≥8)
- NREGS, 32, register count (power of two, ≥2); IW = $clog2(NREGS)
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_function_sel  in  4  ALU op select
- alu_store_1, alu_store_2  in  1  latch bus into operand A / B
- alu_broadcast  in  1  drive alu_out onto bus, update flags
- alu_start  in  1  start multiply (sel=11 only)
- reg_rd_index, reg_wr_index  in  IW  register read / write index
- register_read_enable, register_write_enable  in  1  drive reg onto bus / write bus to reg
- imm  in  WIDTH  immediate value
- imm_EN  in  1  drive imm onto bus
- bus  out  WIDTH  current bus value
- flags  out  4  {Z,N,C,V}
- bus_conflict  out  1  more than one bus source enabled (combinational)
- mul_busy, mul_done  out  1  multiplier handshake

## Operation
- Bus mux, no tristates: priority imm_EN > alu_broadcast > register_read_enable; no source → bus = 0. bus_conflict = 1 when ≥2 of the three enables are high.
- Register read is combinational from reg_rd_index; ZERO_REG=1 and index 0 → 0.
- At each rising edge: alu_store_1 → A ≤ bus; alu_store_2 → B ≤ bus; register_write_enable → reg[reg_wr_index] ≤ bus (dropped for index 0 when ZERO_REG=1). Read-during-write to the same index returns the old value in that cycle.
- ALU (combinational on A, B), sel:
  - 0: zero
  - 1: A+B
  - 2: A−B
  - 3: AND
  - 4: OR
  - 5: XOR
  - 6: A<<B[log2(WIDTH)−1:0]
  - 7: logical shift right
  - 8: arithmetic shift right
  - 9: signed A<B → 1 : 0
  - 10: unsigned A<B → 1 : 0
  - 11: mul_result
  - 12–15: zero
- Flags latch at an edge only when alu_broadcast=1:
  - Z = (alu_out==0); N = alu_out[WIDTH−1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = 1 when there is no borrow (A ≥ B unsigned); V = signed overflow.
  - All other ops: C = V = 0.
- Multiplier is a two-state FSM, IDLE and BUSY.
  - IDLE→BUSY on an edge with alu_start=1 and sel=11. At that edge it copies A and B into private registers and clears the accumulator. alu_start with any other sel, or while BUSY, is ignored.
  - BUSY performs one shift-add step per edge for WIDTH steps, then returns to IDLE and loads mul_result with the low WIDTH bits of the product.
  - A and B may be rewritten during BUSY without affecting the result.
  - mul_result holds until the next completion. Broadcasting sel=11 during BUSY drives the previous mul_result.

## Timing
- Reset (reset_n=0, asynchronous) clears: all registers, A, B, flags, mul_result, the accumulator and FSM (IDLE). While combinational inputs are idle: bus=0, flags=0, mul_busy=0, mul_done=0, bus_conflict=0.
- Reset during BUSY aborts the multiply immediately; no mul_done follows.
- Operand, register and flag updates take effect 1 edge after the enables are sampled. alu_out and bus are combinational (same cycle).
- Multiply started at edge T:
  - mul_busy=1 from T until edge T+WIDTH.
  - mul_done=1 for exactly one cycle, T+WIDTH to T+WIDTH+1; mul_result is valid from T+WIDTH.
  - alu_start is accepted in the mul_done cycle (back-to-back, mul_busy re-asserts at T+WIDTH+1 edge).
- Simultaneous store and broadcast: alu_store_1 with alu_broadcast latches the pre-edge alu_out into A; the flags use the same value.

## Test plan
- Reset mid-op: drive imm=5, imm_EN, write reg 3, then pulse reset_n low → reg 3 reads 0, flags=0, A=B=0, mul_busy=0.
- Priority/conflict: imm_EN=1, register_read_enable=1 (reg 2=7), imm=9 → bus=9, bus_conflict=1. Repeat with only the reg enable → bus=7, bus_conflict=0.
- ADD/SUB flags: A=0xFFFFFFFF, B=1, ADD broadcast → bus=0, flags Z=1,N=0,C=1,V=0. A=0x7FFFFFFF, B=0xFFFFFFFF, SUB → 0x80000000, N=1,C=0,V=1.
- ZERO_REG and read-during-write: write 0xAB to reg 0 → reads 0. Write 0x11 to reg 4 while reading reg 4 → old value that cycle, 0x11 next.
- Multiply: A=0x00012345, B=0x00000100, start → mul_busy for exactly 32 cycles, single-cycle mul_done, sel=11 broadcast → 0x01234500. Rewriting A during BUSY does not change the result.
- Handshake edges:
  - alu_start with sel=1 → no busy.
  - alu_start while BUSY → ignored, one done only.
  - Restart in the done cycle → second busy window follows immediately.
  - A=B=0xFFFFFFFF → result 0x00000001.
